// File: rtl/mmm_serial_multiplier.sv
// Bit-serial Montgomery multiplier: result = A*B*2^-WIDTH mod M.
// Ports: clk, rstb (async low), ena, start, op_a/op_b/modulus in; result, busy, done out.
module mmm_serial_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    p_q, p_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;

  logic [PW-1:0]    t_sum;
  logic [PW-1:0]    u_sum;
  logic [WIDTH-1:0] diff;

  // P < 2M keeps both partial sums below 2^(WIDTH+2).
  always_comb begin
    t_sum = p_q + (a_q[0] ? {2'b00, b_q} : '0);
    u_sum = t_sum + (t_sum[0] ? {2'b00, m_q} : '0);
    // P - M < M < 2^WIDTH, so modulo-2^WIDTH subtraction is exact.
    diff  = p_q[WIDTH-1:0] - m_q;
  end

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          m_d     = modulus;
          p_d     = '0;
          cnt_d   = '0;
          state_d = ITER;
        end
      end
      ITER: begin
        p_d   = u_sum >> 1;
        a_d   = a_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        if (p_q >= {2'b00, m_q}) begin
          res_d = diff;
        end else begin
          res_d = p_q[WIDTH-1:0];
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
      p_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else if (ena) begin
      state_q <= state_d;
      p_q     <= p_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign result = res_q;
  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);

endmodule

// File: tb/tb_mmm_serial_multiplier.sv
// Testbench for mmm_serial_multiplier (WIDTH=8).
// Table vectors, random ops vs. arithmetic model, multi-cycle corner cases.
module tb_mmm_serial_multiplier;

  logic       clk;
  logic       rstb;
  logic       ena;
  logic       start;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [7:0] modulus;
  logic [7:0] result;
  logic       busy;
  logic       done;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int pulses = 0;
  logic done_prev = 1'b0;

  mmm_serial_multiplier #(.WIDTH(8)) dut (
    .clk     (clk),
    .rstb    (rstb),
    .ena     (ena),
    .start   (start),
    .op_a    (op_a),
    .op_b    (op_b),
    .modulus (modulus),
    .result  (result),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (done && !done_prev) pulses++;
    done_prev = done;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] m;
    logic [7:0] exp;
  } vec_t;

  // Find x in [0,M) with x*2^8 == A*B (mod M).
  function automatic int ref_mmm(int a, int b, int m);
    int ab;
    ab = (a * b) % m;
    for (int x = 0; x < m; x++) begin
      if (((x * 256) % m) == ab) return x;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Starts one operation and waits for done; optional ena freeze
  // (5 cycles) and injected start pulse at a given cycle count.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] m, input int frz_at,
                        input int inj_at, output logic [7:0] res,
                        output int lat, output int bc);
    @(negedge clk);
    op_a = a;
    op_b = b;
    modulus = m;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    bc = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy) bc++;
      if (lat == frz_at) ena = 1'b0;
      if (frz_at >= 0 && lat == frz_at + 5) ena = 1'b1;
      if (lat == inj_at) begin
        op_a = 8'd5;
        op_b = 8'd7;
        modulus = 8'd101;
        start = 1'b1;
      end
      if (inj_at >= 0 && lat == inj_at + 1) start = 1'b0;
    end while (!done && lat < 60);
    res = result;
  endtask

  vec_t vecs[6];
  logic [7:0] res;
  int lat;
  int bc;
  int p0;

  initial begin
    logic [7:0] ba[3];
    logic [7:0] bb[3];
    int idx;
    int t_last;

    vecs[0] = '{a: 8'd1,   b: 8'd17,  m: 8'd239, exp: 8'd1};
    vecs[1] = '{a: 8'd238, b: 8'd238, m: 8'd239, exp: 8'd225};
    vecs[2] = '{a: 8'd238, b: 8'd1,   m: 8'd239, exp: 8'd14};
    vecs[3] = '{a: 8'd0,   b: 8'd200, m: 8'd239, exp: 8'd0};
    vecs[4] = '{a: 8'd200, b: 8'd0,   m: 8'd239, exp: 8'd0};
    vecs[5] = '{a: 8'd1,   b: 8'd1,   m: 8'd239, exp: 8'd225};

    rstb = 1'b0;
    ena = 1'b1;
    start = 1'b0;
    op_a = '0;
    op_b = '0;
    modulus = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_result", result, 0);
    rstb = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].m, -1, -1, res, lat, bc);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), lat, 10);
      check($sformatf("vec%0d_busy", i), bc, 10);
      @(negedge clk);
      check($sformatf("vec%0d_done_low", i), done, 0);
      check($sformatf("vec%0d_busy_low", i), busy, 0);
    end

    // start during ITER is ignored
    p0 = pulses;
    run_op(8'd238, 8'd238, 8'd239, -1, 3, res, lat, bc);
    check("inj_result", res, 225);
    check("inj_latency", lat, 10);
    repeat (15) @(negedge clk);
    check("inj_pulses", pulses - p0, 1);
    check("inj_result_hold", result, 225);

    // ena dropped for 5 cycles mid-ITER
    run_op(8'd238, 8'd238, 8'd239, 3, -1, res, lat, bc);
    check("frz_result", res, 225);
    check("frz_latency", lat, 15);
    ena = 1'b0;
    @(negedge clk);
    check("frz_done_held", done, 1);
    ena = 1'b1;
    @(negedge clk);
    check("frz_done_clear", done, 0);

    // asynchronous reset mid-ITER
    @(negedge clk);
    op_a = 8'd1;
    op_b = 8'd17;
    modulus = 8'd239;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rstb = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_result", result, 0);
    @(negedge clk);
    rstb = 1'b1;
    run_op(8'd200, 8'd100, 8'd239, -1, -1, res, lat, bc);
    check("arst_next_result", res, ref_mmm(200, 100, 239));
    check("arst_next_latency", lat, 10);

    // start held high: back-to-back operations
    ba[0] = 8'd238; bb[0] = 8'd238;
    ba[1] = 8'd17;  bb[1] = 8'd99;
    ba[2] = 8'd123; bb[2] = 8'd45;
    idx = 0;
    t_last = -1;
    @(negedge clk);
    op_a = ba[0];
    op_b = bb[0];
    modulus = 8'd239;
    start = 1'b1;
    for (int n = 0; n < 60 && idx < 3; n++) begin
      @(negedge clk);
      if (done) begin
        check($sformatf("b2b%0d_result", idx), result,
              ref_mmm(ba[idx], bb[idx], 239));
        if (idx > 0) check($sformatf("b2b%0d_spacing", idx), cyc - t_last, 11);
        t_last = cyc;
        idx++;
        if (idx < 3) begin
          op_a = ba[idx];
          op_b = bb[idx];
        end else begin
          start = 1'b0;
        end
      end
    end
    check("b2b_count", idx, 3);

    // random operands against the arithmetic model
    for (int r = 0; r < 30; r++) begin
      int m;
      int a;
      int b;
      m = 2 * $urandom_range(1, 127) + 1;
      a = $urandom_range(0, m - 1);
      b = $urandom_range(0, m - 1);
      run_op(8'(a), 8'(b), 8'(m), -1, -1, res, lat, bc);
      check($sformatf("rnd%0d_result(a=%0d b=%0d m=%0d)", r, a, b, m),
            res, ref_mmm(a, b, m));
      check($sformatf("rnd%0d_latency", r), lat, 10);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
